// File: rtl/arbiter4_rr.sv
// Four-requester round-robin arbiter with grant hold and hold timeout.
// Issues a registered one-hot grant. The 2-bit owner index is produced by encoder42.

// 4:2 encoder for a one-hot (or all-zero) input; all-zero encodes to 00.
module encoder42 (
   input  logic i0,
   input  logic i1,
   input  logic i2,
   input  logic i3,
   output logic o0,
   output logic o1
);

   assign o1 = i3 | i2;
   assign o0 = i3 | i1;

endmodule

module arbiter4_rr #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i0,
   input  logic i1,
   input  logic i2,
   input  logic i3,
   output logic gnt0,
   output logic gnt1,
   output logic gnt2,
   output logic gnt3,
   output logic o0,
   output logic o1,
   output logic busy,
   output logic timeout
);

   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StGrant = 1'b1;

   localparam logic [7:0] MaxHold = 8'(MAX_HOLD);
   localparam logic [7:0] HoldSat = 8'd255;

   logic [0:0] state_q, state_d;
   logic [1:0] ptr_q, ptr_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic [1:0] owner_q, owner_d;
   logic [3:0] gnt_q, gnt_d;
   logic       timeout_q, timeout_d;

   logic [3:0] req;
   logic       found;
   logic [1:0] winner;
   logic [1:0] idx;
   logic       hold_expired;

   assign req = {i3, i2, i1, i0};

   // Zero disables the timeout, so expiry can only fire for a nonzero limit.
   assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_q >= MaxHold);

   // First asserted request searching upward from ptr, wrapping mod 4.
   always_comb begin
      found  = 1'b0;
      winner = ptr_q;
      idx    = ptr_q;
      for (int j = 0; j < 4; j++) begin
         idx = ptr_q + 2'(j);
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   // Next-state logic for the IDLE/GRANT machine.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      owner_d    = owner_q;
      gnt_d      = gnt_q;
      timeout_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (found) begin
               state_d        = StGrant;
               owner_d        = winner;
               hold_cnt_d     = 8'd1;
               gnt_d          = 4'b0000;
               gnt_d[winner]  = 1'b1;
            end
         end
         StGrant: begin
            if (!req[owner_q]) begin
               state_d = StIdle;
               gnt_d   = 4'b0000;
               ptr_d   = owner_q + 2'd1;
            end else if (hold_expired) begin
               // Revoked owner goes to lowest priority by moving ptr past it.
               state_d   = StIdle;
               gnt_d     = 4'b0000;
               ptr_d     = owner_q + 2'd1;
               timeout_d = 1'b1;
            end else if (hold_cnt_q != HoldSat) begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = 4'b0000;
         end
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         ptr_q      <= 2'd0;
         hold_cnt_q <= 8'd0;
         owner_q    <= 2'd0;
         gnt_q      <= 4'b0000;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         owner_q    <= owner_d;
         gnt_q      <= gnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign gnt0    = gnt_q[0];
   assign gnt1    = gnt_q[1];
   assign gnt2    = gnt_q[2];
   assign gnt3    = gnt_q[3];
   assign busy    = |gnt_q;
   assign timeout = timeout_q;

   encoder42 u_enc (
      .i0(gnt_q[0]),
      .i1(gnt_q[1]),
      .i2(gnt_q[2]),
      .i3(gnt_q[3]),
      .o0(o0),
      .o1(o1)
   );

endmodule

// File: tb/tb_arbiter4_rr.sv
// Bench for arbiter4_rr: three instances (MAX_HOLD 16, 4, 0) share one request stream
// and are compared each cycle against a behavioural round-robin model.
module tb_arbiter4_rr;

   logic       clk;
   logic       reset_n;
   logic [3:0] req;

   logic [2:0][3:0] gnt_v;
   logic [2:0][1:0] enc_v;
   logic [2:0]      busy_v;
   logic [2:0]      to_v;

   int total;
   int bad;

   // Model state per instance: owner (-1 when idle), cycles held, next priority.
   int m_own [3];
   int m_len [3];
   int m_ptr [3];
   bit m_to  [3];
   int mh    [3];

   int  grant_order [$];
   bit  prev_busy;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   arbiter4_rr #(.MAX_HOLD(16)) u_def (
      .clk(clk), .reset_n(reset_n),
      .i0(req[0]), .i1(req[1]), .i2(req[2]), .i3(req[3]),
      .gnt0(gnt_v[0][0]), .gnt1(gnt_v[0][1]), .gnt2(gnt_v[0][2]), .gnt3(gnt_v[0][3]),
      .o0(enc_v[0][0]), .o1(enc_v[0][1]), .busy(busy_v[0]), .timeout(to_v[0])
   );

   arbiter4_rr #(.MAX_HOLD(4)) u_to (
      .clk(clk), .reset_n(reset_n),
      .i0(req[0]), .i1(req[1]), .i2(req[2]), .i3(req[3]),
      .gnt0(gnt_v[1][0]), .gnt1(gnt_v[1][1]), .gnt2(gnt_v[1][2]), .gnt3(gnt_v[1][3]),
      .o0(enc_v[1][0]), .o1(enc_v[1][1]), .busy(busy_v[1]), .timeout(to_v[1])
   );

   arbiter4_rr #(.MAX_HOLD(0)) u_nt (
      .clk(clk), .reset_n(reset_n),
      .i0(req[0]), .i1(req[1]), .i2(req[2]), .i3(req[3]),
      .gnt0(gnt_v[2][0]), .gnt1(gnt_v[2][1]), .gnt2(gnt_v[2][2]), .gnt3(gnt_v[2][3]),
      .o0(enc_v[2][0]), .o1(enc_v[2][1]), .busy(busy_v[2]), .timeout(to_v[2])
   );

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_own[k] = -1;
         m_len[k] = 0;
         m_ptr[k] = 0;
         m_to[k]  = 1'b0;
      end
   endtask

   // One rising edge of the arbitration rules applied to the current request lines.
   task automatic model_edge();
      int idx;
      for (int k = 0; k < 3; k++) begin
         if (m_own[k] < 0) begin
            m_to[k] = 1'b0;
            for (int j = 0; j < 4; j++) begin
               idx = (m_ptr[k] + j) % 4;
               if (m_own[k] < 0 && req[idx]) begin
                  m_own[k] = idx;
                  m_len[k] = 1;
               end
            end
         end else if (!req[m_own[k]]) begin
            m_ptr[k] = (m_own[k] + 1) % 4;
            m_own[k] = -1;
            m_to[k]  = 1'b0;
         end else if (mh[k] != 0 && m_len[k] >= mh[k]) begin
            m_ptr[k] = (m_own[k] + 1) % 4;
            m_own[k] = -1;
            m_to[k]  = 1'b1;
         end else begin
            m_len[k] = m_len[k] + 1;
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [3:0] eg;
      logic [1:0] ee;
      logic       eb;
      for (int k = 0; k < 3; k++) begin
         eg = 4'b0000;
         ee = 2'b00;
         eb = 1'b0;
         if (m_own[k] >= 0) begin
            eg = 4'b0001;
            eg = eg << m_own[k];
            ee = 2'(m_own[k]);
            eb = 1'b1;
         end
         total++;
         assert (gnt_v[k] === eg) else begin
            bad++;
            $error("FAIL %s[%0d] gnt observed=%b expected=%b", tag, k, gnt_v[k], eg);
         end
         total++;
         assert (enc_v[k] === ee) else begin
            bad++;
            $error("FAIL %s[%0d] o1o0 observed=%b expected=%b", tag, k, enc_v[k], ee);
         end
         total++;
         assert (busy_v[k] === eb) else begin
            bad++;
            $error("FAIL %s[%0d] busy observed=%b expected=%b", tag, k, busy_v[k], eb);
         end
         total++;
         assert (to_v[k] === m_to[k]) else begin
            bad++;
            $error("FAIL %s[%0d] timeout observed=%b expected=%b", tag, k, to_v[k], m_to[k]);
         end
      end
   endtask

   // Advance one clock: model follows the rising edge, outputs checked at the falling edge.
   task automatic step(input string tag);
      @(posedge clk);
      if (reset_n) model_edge();
      @(negedge clk);
      check_all(tag);
   endtask

   // Asynchronous reset asserted between edges, checked before the next rising edge.
   task automatic async_reset(input string tag);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      step(tag);
      reset_n = 1'b1;
   endtask

   initial begin
      int exp_order [5];
      total = 0;
      bad   = 0;
      mh[0] = 16;
      mh[1] = 4;
      mh[2] = 0;
      exp_order = '{0, 1, 2, 3, 0};

      // Reset with every request high: outputs idle without any clock edge.
      reset_n = 1'b0;
      req     = 4'b1111;
      model_reset();
      #1;
      check_all("reset_noclk");
      step("reset_held");
      step("reset_held");
      reset_n = 1'b1;
      step("first_grant");
      req = 4'b0000;
      step("first_release");
      step("idle");

      // Single requester on line 2 held for five edges, then a 3/0 pair to show ptr=3.
      req = 4'b0100;
      for (int n = 0; n < 5; n++) step("single2");
      req = 4'b0000;
      step("single2_drop");
      req = 4'b1001;
      step("ptr3_pick");
      req = 4'b0000;
      step("ptr3_drop");
      step("idle");

      // Contention with rotation from a fresh reset: each owner drops after three cycles.
      async_reset("pre_rotate_reset");
      prev_busy = 1'b0;
      grant_order.delete();
      for (int n = 0; n < 24; n++) begin
         req = 4'b1111;
         if (m_own[0] >= 0 && m_len[0] == 3) req[m_own[0]] = 1'b0;
         step("rotate");
         if (busy_v[0] && !prev_busy) grant_order.push_back(int'(enc_v[0]));
         prev_busy = busy_v[0];
      end
      total++;
      assert (grant_order.size() >= 5) else begin
         bad++;
         $error("FAIL rotate_count observed=%0d expected>=5", grant_order.size());
      end
      for (int n = 0; n < 5; n++) begin
         if (n < grant_order.size()) begin
            total++;
            assert (grant_order[n] == exp_order[n]) else begin
               bad++;
               $error("FAIL rotate_order[%0d] observed=%0d expected=%0d", n, grant_order[n],
                      exp_order[n]);
            end
         end
      end
      req = 4'b0000;
      step("idle");
      step("idle");

      // Lines 1 and 3 held continuously: the MAX_HOLD=4 instance alternates on timeout.
      req = 4'b1010;
      for (int n = 0; n < 25; n++) step("timeout_pair");
      req = 4'b0000;
      step("idle");
      step("idle");

      // Long hold on line 0 with line 1 waiting; only the MAX_HOLD=0 instance keeps it.
      async_reset("pre_long_reset");
      req = 4'b0011;
      for (int n = 0; n < 310; n++) step("long_hold");
      total++;
      assert (gnt_v[2] === 4'b0001) else begin
         bad++;
         $error("FAIL long_hold_owner observed=%b expected=0001", gnt_v[2]);
      end
      req = 4'b0000;
      step("idle");
      step("idle");

      // Get owner 3 with ptr=3, reset mid-cycle, then restart from ptr 0.
      req = 4'b0100;
      step("mid_pre2");
      req = 4'b0000;
      step("mid_drop2");
      req = 4'b1000;
      step("mid_gnt3");
      step("mid_gnt3");
      async_reset("mid_reset");
      total++;
      assert (gnt_v[0] === 4'b0000) else begin
         bad++;
         $error("FAIL mid_reset_gnt observed=%b expected=0000", gnt_v[0]);
      end
      req = 4'b1010;
      step("after_reset");
      total++;
      assert (gnt_v[0] === 4'b0010) else begin
         bad++;
         $error("FAIL after_reset_gnt1 observed=%b expected=0010", gnt_v[0]);
      end
      req = 4'b0000;
      step("idle");
      step("idle");

      // Random request traffic with occasional mid-cycle reset.
      for (int n = 0; n < 500; n++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 9) < 3) req[b] = ~req[b];
         end
         if ($urandom_range(0, 99) == 0) async_reset("rand_reset");
         else step("random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/arbiter4_rr.md
# arbiter4_rr

Four-requester round-robin arbiter with grant hold and timeout, owning a single shared resource that is addressed by a 2-bit index. It accepts four request lines and issues one registered one-hot grant. It also drives the 2-bit 4:2 encoding of that grant, built from an encoder42 instance, so downstream muxes can select the owner directly. It is the sequencing/sharing front end for the encoder42-indexed datapath.

## Interface
- MAX_HOLD, 16, maximum consecutive cycles one requester may hold the grant; legal range 0..255; 0 disables the timeout.
- clk  input  1  single system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- i0..i3  input  1 each  request from requester 0..3; level-sensitive, held high until done.
- gnt0..gnt3  output  1 each  registered one-hot grant to requester 0..3.
- o0, o1  output  1 each  encoded grant index, o1 = gnt3|gnt2, o0 = gnt3|gnt1; 00 when no grant.
- busy  output  1  high whenever any gntN is high.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

## Operation
- State machine with two states: IDLE and GRANT. Reset state is IDLE.
- Internal state:
  - ptr, 2 bits, is the highest-priority index; reset value 0.
  - hold_cnt, 8 bits, reset value 0.
  - owner, 2 bits, reset value 0.
- Transition IDLE to GRANT: taken at a rising edge where any iN=1.
  - Winner is the first asserted request searching ptr, ptr+1, ptr+2, ptr+3, mod 4.
  - gnt[winner] is set, owner = winner, hold_cnt = 1.
- GRANT hold: stays in GRANT while i[owner]=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD). hold_cnt increments each cycle and saturates at 255.
- Transition GRANT to IDLE on release: taken at an edge where i[owner]=0. All gnt are cleared and ptr = owner+1 mod 4, so 3 wraps to 0.
- Transition GRANT to IDLE on timeout: taken at an edge where i[owner]=1 and hold_cnt==MAX_HOLD (MAX_HOLD≠0).
  - All gnt are cleared, ptr = owner+1 mod 4, and timeout is asserted for that one cycle.
  - The revoked requester re-enters arbitration at lowest priority.
- Changes on non-owner request lines during GRANT are ignored; no preemption.
- Requests that arrive in the same cycle are resolved purely by ptr order.
- o0/o1 and busy are combinational from the registered gnt bits, so they are glitch-free relative to clk.

## Timing
- Reset values: gnt0..gnt3=0, o0=o1=0, busy=0, timeout=0. These apply immediately on reset_n low, independent of clk.
- Grant latency is 1 cycle: a request sampled high at edge k in IDLE drives gnt high after edge k.
- Release latency is 1 cycle: i[owner] sampled low at edge k clears gnt after edge k.
- At least one IDLE cycle separates consecutive grants, so back-to-back ownership change costs 2 cycles (grant off, then new grant).
- Maximum continuous grant is MAX_HOLD cycles. The timeout pulse coincides with the first cycle of gnt low.
- Reset mid-GRANT clears gnt, ptr, hold_cnt and state asynchronously. After reset_n rises, arbitration restarts from ptr=0 at the next edge.
- If a requester drops and re-raises its request within the release cycle, it is treated as a new request and arbitrated with ptr already advanced.

## Test plan
- Reset: reset_n=0 with all iN=1 -> all gnt=0, o1o0=00, busy=0, timeout=0. After release, the first edge grants gnt0 (ptr=0).
- Single requester: i2=1 held 5 cycles, then dropped -> gnt2 high 1 cycle after the first edge, for 5 cycles, o1o0=10. gnt2 low 1 cycle after the drop; ptr becomes 3.
- Simultaneous contention with rotation: i0..i3 all held high, each requester drops after 3 granted cycles then re-raises -> grant order 0,1,2,3,0. The wrap 3 to 0 is shown, with one idle cycle between grants.
- Timeout: MAX_HOLD=4, i1 and i3 held high continuously -> gnt1 for 4 cycles, then timeout=1 for 1 cycle with gnt low, then gnt3 for 4 cycles, then gnt1 again.
- No timeout: MAX_HOLD=0, i0 held high for 300 cycles with i1=1 -> gnt0 continuous for 300 cycles, no timeout pulse, hold_cnt saturates without wrap.
- Reset mid-grant: during gnt3 with ptr=3, assert reset_n=0 asynchronously mid-cycle -> gnt3 falls immediately. After release with i1, i3 high, gnt1 is granted (ptr=0 order).
